// File: rtl/systolic_result_drain.sv
// Result drain for a SIZE x SIZE systolic array: waits out the array latency after
// a start pulse, snapshots the flat C bus, then streams it element by element.
module systolic_result_drain #(
  parameter int SIZE          = 4,
  parameter int O_BITS        = 16,
  parameter int CAPTURE_DELAY = 3*SIZE-2
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [SIZE*SIZE*O_BITS-1:0]   i_c_full,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [O_BITS-1:0]             o_data,
  output logic [$clog2(SIZE)-1:0]       o_row,
  output logic [$clog2(SIZE)-1:0]       o_col,
  output logic                          o_last,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [1:0]                    o_state
);

  localparam int N     = SIZE*SIZE;
  localparam int IDX_W = $clog2(N);
  localparam int RC_W  = $clog2(SIZE);
  localparam int CNT_W = $clog2(CAPTURE_DELAY+1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N-1);
  localparam logic [IDX_W-1:0] IDX_SIZE = IDX_W'(SIZE);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CAPTURE_DELAY-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [O_BITS-1:0]   buf_q [N];
  logic                capture;
  logic                done_q, done_d;

  // Handshake: a beat transfers on a rising edge where o_valid && i_ready. o_valid
  // is a pure function of state, so it never looks at i_ready, and all beat fields
  // hold steady while i_ready is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    capture = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_CAP) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (i_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < N; k++) buf_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      // Snapshot frees the array for the next product while we drain.
      if (capture) begin
        for (int k = 0; k < N; k++) buf_q[k] <= i_c_full[k*O_BITS +: O_BITS];
      end
    end
  end

  assign o_valid = (state_q == S_STREAM);
  assign o_data  = o_valid ? buf_q[idx_q] : '0;
  assign o_row   = o_valid ? RC_W'(idx_q / IDX_SIZE) : '0;
  assign o_col   = o_valid ? RC_W'(idx_q % IDX_SIZE) : '0;
  assign o_last  = o_valid && (idx_q == IDX_LAST);
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done_q;
  assign o_state = state_q;

endmodule
